// File: rtl/loader_pkg.sv
// Shared state encoding and byte-lane constants for the boot program loader.
// LOADER_CHECKSUM_EN adds a trailing XOR checksum byte that is verified before DONE.
package loader_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_LANES = 4;
  localparam int WORD_W     = BYTE_W * WORD_LANES;

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t LOAD_END = CHECK;
`else
  localparam state_t LOAD_END = DONE;
`endif

  function automatic logic [31:0] word_addr(input logic [15:0] idx);
    return {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write bus of the program loader.
interface program_loader_if;
  import loader_pkg::*;

  logic [BYTE_W-1:0] Byte_i;
  logic              Byte_Valid_i;
  logic              Byte_Ready_o;
  logic              Mem_Write_o;
  logic [31:0]       Address_o;
  logic [WORD_W-1:0] Write_Data_o;

  modport slave  (input  Byte_i, Byte_Valid_i,
                  output Byte_Ready_o, Mem_Write_o, Address_o, Write_Data_o);
  modport master (output Byte_i, Byte_Valid_i,
                  input  Byte_Ready_o, Mem_Write_o, Address_o, Write_Data_o);

endinterface

// File: rtl/program_loader_word_assembler.sv
// Packs four accepted bytes little-endian into one word; word_done_o fires
// combinationally with the fourth byte, word_o is valid in that same cycle.
module Word_Assembler
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              byte_vld_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              word_done_o,
  output logic [WORD_W-1:0] word_o
);

  logic [1:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clear_i) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (byte_vld_i) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {byte_i, shift_q[WORD_W-1:BYTE_W]};
    end
  end

  // Newest byte enters at the top so the first byte ends up in bits 7:0.
  assign word_o      = {byte_i, shift_q[WORD_W-1:BYTE_W]};
  assign word_done_o = byte_vld_i && !clear_i && (cnt_q == 2'(WORD_LANES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed program image into instruction memory while holding the CPU in reset.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before DONE.
module program_loader
  import loader_pkg::*;
#(
  parameter int MEMORY_DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start_i,
  program_loader_if.slave  bus,
  output logic             Cpu_Hold_o,
  output logic             Busy_o,
  output logic             Done_o,
  output logic             Error_o
);

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       idx_q, idx_d;
  logic [31:0]       addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d;
`endif

  logic              rdy, acc, start_go, word_done;
  logic [WORD_W-1:0] word;
  logic [15:0]       len_full;

  assign rdy      = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                    (state_q == DATA)   || (state_q == CHECK);
  assign acc      = rdy && bus.Byte_Valid_i;
  assign start_go = Start_i && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
  assign len_full = {bus.Byte_i, len_q[7:0]};

  Word_Assembler u_asm (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (start_go),
    .byte_vld_i  (acc && (state_q == DATA)),
    .byte_i      (bus.Byte_i),
    .word_done_o (word_done),
    .word_o      (word)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (Start_i) begin
          state_d = LEN_LO;
          len_d   = '0;
          idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      LEN_LO: begin
        if (acc) begin
          len_d[7:0] = bus.Byte_i;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (acc) begin
          len_d = len_full;
          if ({16'd0, len_full} > 32'(MEMORY_DEPTH)) state_d = ERROR;
          else if (len_full == 16'd0)                state_d = LOAD_END;
          else                                       state_d = DATA;
        end
      end
      DATA: begin
        if (acc) begin
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ bus.Byte_i;
`endif
          if (word_done) begin
            addr_d  = word_addr(idx_q);
            wdata_d = word;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        idx_d   = idx_q + 16'd1;
        state_d = (idx_q + 16'd1 == len_q) ? LOAD_END : DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (acc) state_d = (bus.Byte_i == csum_q) ? DONE : ERROR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign bus.Byte_Ready_o = rdy;
  assign bus.Mem_Write_o  = (state_q == WRITE);
  assign bus.Address_o    = addr_q;
  assign bus.Write_Data_o = wdata_q;

  // IDLE is only reachable through reset, so the CPU is released solely in DONE.
  assign Cpu_Hold_o = (state_q != DONE);
  assign Busy_o     = !((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
  assign Done_o     = (state_q == DONE);
  assign Error_o    = (state_q == ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table-driven loads, hand-written corner sequences and
// random loads compared against a stream-level reference model.
module tb_program_loader;
  import loader_pkg::*;

  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic Start_i = 1'b0;
  logic Cpu_Hold_o, Busy_o, Done_o, Error_o;

  program_loader_if bus();

  program_loader #(.MEMORY_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .Start_i    (Start_i),
    .bus        (bus),
    .Cpu_Hold_o (Cpu_Hold_o),
    .Busy_o     (Busy_o),
    .Done_o     (Done_o),
    .Error_o    (Error_o)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] got[$];
  logic [31:0] wq[$];
  bit          prev_mw = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe is one cycle wide and never overlaps byte acceptance.
  always @(negedge clk) begin
    if (bus.Mem_Write_o === 1'b1) begin
      got.push_back({bus.Address_o, bus.Write_Data_o});
      chk("strobe_one_cycle", 32'(prev_mw), 32'd0);
      chk("ready_low_in_write", 32'(bus.Byte_Ready_o), 32'd0);
    end
    prev_mw = (bus.Mem_Write_o === 1'b1);
  end

  task automatic pulse_start();
    Start_i = 1'b1;
    @(posedge clk); #1;
    Start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int cyc = 0;
    repeat (gap) begin
      bus.Byte_Valid_i = 1'b0;
      bus.Byte_i = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.Byte_i = b;
    bus.Byte_Valid_i = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.Byte_Ready_o) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc > 40) begin
        n_chk++;
        n_fail++;
        $display("FAIL byte_accept_timeout: byte %h not taken after %0d cycles, required within 40", b, cyc);
        break;
      end
    end
    bus.Byte_Valid_i = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int cyc = 0;
    while (!(Done_o || Error_o) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!(Done_o || Error_o)) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_end_timeout: no Done/Error after %0d cycles, required within 20", tag, cyc);
    end
    @(posedge clk); #1;
  endtask

  // Reference model: the stream is the length, the words of wq byte by byte, then
  // (checksum build) the XOR of all data bytes. Lengths over DEPTH stop after the length.
  task automatic run_load(input logic [15:0] len, input bit bad_csum,
                          input int mingap, input int maxgap, input string tag);
    logic [7:0] bytes[$];
    logic [7:0] x = 8'h00;
    bit         exp_ok;
    int         exp_writes;
    exp_ok     = (int'(len) <= DEPTH);
    exp_writes = exp_ok ? int'(len) : 0;
    bytes.push_back(len[7:0]);
    bytes.push_back(len[15:8]);
    if (exp_ok) begin
      for (int i = 0; i < int'(len); i++) begin
        for (int k = 0; k < 4; k++) begin
          bytes.push_back(wq[i][8*k +: 8]);
          x ^= wq[i][8*k +: 8];
        end
      end
`ifdef LOADER_CHECKSUM_EN
      bytes.push_back(bad_csum ? (x ^ 8'h01) : x);
      if (bad_csum) exp_ok = 1'b0;
`endif
    end
    got.delete();
    pulse_start();
    foreach (bytes[i]) send_byte(bytes[i], int'($urandom_range(maxgap, mingap)));
    wait_end(tag);
    chk({tag, "_nwrites"}, 32'(got.size()), 32'(exp_writes));
    for (int i = 0; i < got.size() && i < exp_writes; i++) begin
      chk({tag, "_addr"}, got[i][63:32], 32'(4 * i));
      chk({tag, "_data"}, got[i][31:0], wq[i]);
    end
    chk({tag, "_done"}, 32'(Done_o), 32'(exp_ok));
    chk({tag, "_error"}, 32'(Error_o), 32'(!exp_ok));
    chk({tag, "_hold"}, 32'(Cpu_Hold_o), 32'(!exp_ok));
    chk({tag, "_busy"}, 32'(Busy_o), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ready"}, 32'(bus.Byte_Ready_o), 32'd0);
    chk({tag, "_memwr"}, 32'(bus.Mem_Write_o), 32'd0);
    chk({tag, "_addr"}, bus.Address_o, 32'd0);
    chk({tag, "_wdata"}, bus.Write_Data_o, 32'd0);
    chk({tag, "_hold"}, 32'(Cpu_Hold_o), 32'd1);
    chk({tag, "_busy"}, 32'(Busy_o), 32'd0);
    chk({tag, "_done"}, 32'(Done_o), 32'd0);
    chk({tag, "_error"}, 32'(Error_o), 32'd0);
  endtask

  typedef struct {
    logic [15:0] len;
    logic [31:0] w0;
    logic [31:0] w1;
    int          writes;
    bit          done;
    bit          err;
    bit          hold;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] x;
    logic [15:0] len;
    bus.Byte_i       = 8'h00;
    bus.Byte_Valid_i = 1'b0;

    tbl[0] = '{16'd2,     32'h0000_0013, 32'h0010_0093, 2, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{16'd65,    32'h0,         32'h0,         0, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{16'd0,     32'h0,         32'h0,         0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{16'd1,     32'hDEAD_BEEF, 32'h0,         1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{16'h0100,  32'h1,         32'h2,         0, 1'b0, 1'b1, 1'b1};

    #12;
    check_reset_state("rst_asserted");
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst_released");

    for (int i = 0; i < 5; i++) begin
      wq.delete();
      wq.push_back(tbl[i].w0);
      wq.push_back(tbl[i].w1);
      run_load(tbl[i].len, 1'b0, 0, 0, "tbl");
      chk("tbl_exp_nwrites", 32'(got.size()), 32'(tbl[i].writes));
      chk("tbl_exp_done", 32'(Done_o), 32'(tbl[i].done));
      chk("tbl_exp_error", 32'(Error_o), 32'(tbl[i].err));
      chk("tbl_exp_hold", 32'(Cpu_Hold_o), 32'(tbl[i].hold));
    end

    // Valid toggled every other cycle around a single-word load.
    wq.delete();
    wq.push_back(32'hA5C3_0F81);
    run_load(16'd1, 1'b0, 1, 1, "toggle");

    // Reset after two data bytes: nothing may ever be written.
    got.delete();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    chk("mid_busy_before_reset", 32'(Busy_o), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_state("mid_reset");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_reset_nwrites", 32'(got.size()), 32'd0);
    chk("mid_reset_hold_idle", 32'(Cpu_Hold_o), 32'd1);

    // Start pulse in DATA is ignored.
    got.delete();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h0D, 0);
    send_byte(8'hF0, 0);
    pulse_start();
    chk("start_in_data_busy", 32'(Busy_o), 32'd1);
    send_byte(8'hAD, 1);
    send_byte(8'h0B, 0);
`ifdef LOADER_CHECKSUM_EN
    x = 8'h0D ^ 8'hF0 ^ 8'hAD ^ 8'h0B;
    send_byte(x, 0);
`endif
    wait_end("start_in_data");
    chk("start_in_data_nwrites", 32'(got.size()), 32'd1);
    if (got.size() > 0) chk("start_in_data_word", got[0][31:0], 32'h0BAD_F00D);
    chk("start_in_data_done", 32'(Done_o), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    wq.delete();
    wq.push_back(32'h0000_0013);
    run_load(16'd1, 1'b0, 0, 0, "csum_good");
    run_load(16'd1, 1'b1, 0, 0, "csum_bad");
`endif

    for (int t = 0; t < 12; t++) begin
      int r;
      bit bad;
      r = int'($urandom_range(9, 0));
      if (r < 7)       len = 16'($urandom_range(6, 0));
      else if (r == 7) len = 16'(DEPTH);
      else             len = 16'($urandom_range(300, DEPTH + 1));
      bad = ($urandom_range(3, 0) == 0);
      wq.delete();
      for (int i = 0; i < DEPTH; i++) wq.push_back($urandom);
      run_load(len, bad, 0, 3, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter MEMORY_DEPTH, default 64, meaning program memory capacity in 32-bit words.
REQ-002 SHALL have ports: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have ports: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: Start_i  input  1  one-cycle pulse that begins a load.
REQ-005 SHALL have ports: Byte_i  input  8  incoming stream byte; Byte_Valid_i  input  1  byte present.
REQ-006 SHALL have ports: Byte_Ready_o  output  1  loader accepts Byte_i this cycle.
REQ-007 SHALL have ports: Mem_Write_o  output  1  program-memory write strobe; Address_o  output  32  byte address; Write_Data_o  output  32  instruction word.
REQ-008 SHALL have ports: Cpu_Hold_o  output  1  holds the processor in reset while high; Busy_o, Done_o, Error_o  output  1 each  status.

Function
REQ-009 A byte SHALL transfer only in a cycle where Byte_Valid_i and Byte_Ready_o are both high.
REQ-010 States SHALL be IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR.
REQ-011 Start_i in IDLE, DONE or ERROR SHALL go to LEN_LO, clear Done_o/Error_o, zero word counter and checksum; Start_i in any other state SHALL be ignored.
REQ-012 LEN_LO then LEN_HI SHALL each accept one byte forming 16-bit little-endian word count N.
REQ-013 After LEN_HI: N > MEMORY_DEPTH SHALL go to ERROR; N = 0 SHALL go to CHECK if enabled, else DONE; otherwise DATA.
REQ-014 DATA SHALL assemble four accepted bytes little-endian (first byte -> bits 7:0) into one word, then go to WRITE.
REQ-015 WRITE SHALL last exactly one cycle with Mem_Write_o=1, Address_o=4*word_index, Write_Data_o=assembled word; Byte_Ready_o=0 in WRITE.
REQ-016 After WRITE, word_index SHALL increment; if word_index equals N, go to CHECK if enabled, else DONE; otherwise DATA.
REQ-017 Byte_Ready_o SHALL be high exactly in LEN_LO, LEN_HI, DATA, CHECK.
REQ-018 Mem_Write_o SHALL be high only in WRITE; Address_o/Write_Data_o SHALL hold last values otherwise.
REQ-019 Cpu_Hold_o and Busy_o SHALL be high in every state except IDLE, DONE, ERROR; Cpu_Hold_o also high in ERROR.
REQ-020 Done_o SHALL be high only in DONE; Error_o only in ERROR; both hold until next Start_i or reset.
REQ-021 Byte_Valid_i low SHALL stall any receive state indefinitely with no output change.
REQ-022 Word counter SHALL be 16 bits; address arithmetic SHALL be 32-bit, no wrap possible since N <= MEMORY_DEPTH.

Reset
REQ-023 reset low SHALL immediately force IDLE, Byte_Ready_o=0, Mem_Write_o=0, Address_o=0, Write_Data_o=0, Cpu_Hold_o=1, Busy_o=0, Done_o=0, Error_o=0, counters and checksum zero.
REQ-024 Reset mid-load SHALL abandon the load; partially assembled word SHALL never be written.
REQ-025 In IDLE after reset Cpu_Hold_o SHALL stay 1 until first DONE.

Configuration
REQ-026 Macro LOADER_CHECKSUM_EN defined: XOR of all data bytes accumulated; CHECK accepts one byte; equal -> DONE, unequal -> ERROR.
REQ-027 Macro LOADER_CHECKSUM_EN undefined: CHECK state and accumulator absent; last WRITE (or N=0) goes straight to DONE.

Structure
REQ-028 State encoding typedef and byte-lane constants SHALL live in shared package loader_pkg.
REQ-029 Byte-to-word assembly SHALL be sub-module Word_Assembler (byte counter 0-3, shift register, word-complete flag).

Verification
REQ-030 Reset low mid-DATA after 2 bytes -> IDLE, Cpu_Hold_o=1, no Mem_Write_o pulse ever.
REQ-031 Start, bytes 02 00, 13 00 00 00, 93 00 10 00 -> writes 0x00000013 @0x0, 0x00100093 @0x4, Done_o=1, Cpu_Hold_o=0.
REQ-032 Start, N=65 with MEMORY_DEPTH=64 -> ERROR after LEN_HI, no writes, Cpu_Hold_o=1.
REQ-033 N=1 with Byte_Valid_i toggled every other cycle -> single correct write, one-cycle strobe, Byte_Ready_o=0 during WRITE.
REQ-034 LOADER_CHECKSUM_EN, N=1 data 13 00 00 00, checksum 13 -> Done_o=1; checksum 12 -> Error_o=1.
REQ-035 Start_i pulsed during DATA -> ignored, load completes unchanged.
